// File: rtl/led_display_arbiter.sv
// Round-robin arbiter sharing one serial LED driver between N_REQ requesters.
// Captures the winner's word, strobes the driver, then waits for its latch pulse or a timeout.
module led_display_arbiter #(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = 16,
  parameter int TIMEOUT  = 1023,
  parameter int HOLD_CYC = 8
) (
  input  logic                    i_CLK,
  input  logic                    i_RESET,
  input  logic [N_REQ-1:0]        i_Req,
  input  logic [N_REQ*DATA_W-1:0] i_Data,
  output logic [N_REQ-1:0]        o_Grant,
  output logic [N_REQ-1:0]        o_Done,
  output logic                    o_TimeoutErr,
  output logic [DATA_W-1:0]       o_Data16,
  output logic                    o_Start,
  input  logic                    i_LEDLatch,
  output logic                    o_Busy
);

  // state      | meaning
  // IDLE       | waiting for any request; arbitrates on the edge a request is seen
  // START      | word captured, start strobe issued to the driver
  // WAIT_LATCH | waiting for a driver latch rising edge or timeout
  // HOLD       | latched word kept on display for HOLD_CYC cycles

  localparam int PTR_W     = (N_REQ > 2) ? $clog2(N_REQ) : 1;
  localparam int TMR_MAX   = (TIMEOUT > HOLD_CYC) ? TIMEOUT : HOLD_CYC;
  localparam int TMR_W     = $clog2(TMR_MAX + 1);
  localparam int HOLD_LAST = (HOLD_CYC > 0) ? HOLD_CYC - 1 : 0;

  typedef enum logic [1:0] {IDLE, START, WAIT_LATCH, HOLD} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               latch_prev_q;
  logic [N_REQ-1:0]   grant_d, done_d;
  logic               tmo_d, start_d, busy_d;
  logic [DATA_W-1:0]  data_d;

  logic [DATA_W-1:0]  words [N_REQ];
  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W:0]     sum;
  logic               latch_rise;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      words[i] = i_Data[i*DATA_W +: DATA_W];
    end
  end

  // Search upward from the RR pointer, wrapping modulo N_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    sum       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, ptr_q} + (PTR_W+1)'(i);
      if (sum >= (PTR_W+1)'(N_REQ)) sum = sum - (PTR_W+1)'(N_REQ);
      if (!win_found && i_Req[sum[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = sum[PTR_W-1:0];
      end
    end
  end

  assign latch_rise = i_LEDLatch & ~latch_prev_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    timer_d = timer_q;
    data_d  = o_Data16;
    grant_d = '0;
    done_d  = '0;
    tmo_d   = 1'b0;
    start_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          data_d           = words[win_idx];
          owner_d          = win_idx;
          grant_d[win_idx] = 1'b1;
          ptr_d            = (win_idx == PTR_W'(N_REQ-1)) ? '0 : win_idx + 1'b1;
          state_d          = START;
        end
      end
      START: begin
        start_d = 1'b1;
        timer_d = '0;
        state_d = WAIT_LATCH;
      end
      WAIT_LATCH: begin
        // A latch edge on the final timeout cycle still counts as a completed frame.
        if (latch_rise) begin
          done_d[owner_q] = 1'b1;
          timer_d         = '0;
          state_d         = (HOLD_CYC > 0) ? HOLD : IDLE;
        end else if (timer_q == TMR_W'(TIMEOUT-1)) begin
          tmo_d   = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      HOLD: begin
        if (timer_q >= TMR_W'(HOLD_LAST)) state_d = IDLE;
        else                              timer_d = timer_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_CLK or negedge i_RESET) begin
    if (!i_RESET) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      owner_q      <= '0;
      timer_q      <= '0;
      latch_prev_q <= 1'b0;
      o_Grant      <= '0;
      o_Done       <= '0;
      o_TimeoutErr <= 1'b0;
      o_Start      <= 1'b0;
      o_Busy       <= 1'b0;
      o_Data16     <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      timer_q      <= timer_d;
      latch_prev_q <= i_LEDLatch;
      o_Grant      <= grant_d;
      o_Done       <= done_d;
      o_TimeoutErr <= tmo_d;
      o_Start      <= start_d;
      o_Busy       <= busy_d;
      o_Data16     <= data_d;
    end
  end

endmodule

// File: tb/tb_led_display_arbiter.sv
// Bench for led_display_arbiter: vector table, hand-written corner sequences and
// randomized frames checked against a transaction-level round-robin model.
module tb_led_display_arbiter;
  localparam int N = 4;
  localparam int W = 16;
  localparam int TMO = 1023;
  localparam int HOLD_CYC = 8;

  logic           i_CLK = 1'b0;
  logic           i_RESET = 1'b0;
  logic [N-1:0]   i_Req = '0;
  logic [N*W-1:0] i_Data = '0;
  logic [N-1:0]   o_Grant, o_Done;
  logic           o_TimeoutErr, o_Start, o_Busy;
  logic [W-1:0]   o_Data16;
  logic           i_LEDLatch = 1'b0;

  int n_checks = 0;
  int n_err = 0;

  led_display_arbiter #(.N_REQ(N), .DATA_W(W), .TIMEOUT(TMO), .HOLD_CYC(HOLD_CYC)) dut (
    .i_CLK(i_CLK), .i_RESET(i_RESET), .i_Req(i_Req), .i_Data(i_Data),
    .o_Grant(o_Grant), .o_Done(o_Done), .o_TimeoutErr(o_TimeoutErr),
    .o_Data16(o_Data16), .o_Start(o_Start), .i_LEDLatch(i_LEDLatch), .o_Busy(o_Busy)
  );

  always #5 i_CLK = ~i_CLK;

  typedef struct {
    logic [N-1:0] req;
    int           lat;
    int           w;
    logic [W-1:0] d;
    bit           drop;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_CLK);
    #1;
  endtask

  task automatic do_reset();
    i_Req = '0;
    i_LEDLatch = 1'b0;
    i_RESET = 1'b0;
    repeat (3) tick();
    i_RESET = 1'b1;
    tick();
  endtask

  task automatic wait_grant(output bit ok);
    int n = 0;
    while (o_Grant == '0 && n < 40) begin
      tick();
      n++;
    end
    ok = (o_Grant != '0);
    if (!ok) check("grant_wait", 32'd0, 32'd1);
  endtask

  // One full frame: request, grant, start, latch after lat cycles, hold.
  task automatic run_frame(input logic [N-1:0] req, input int lat, input int w,
                           input logic [W-1:0] d, input bit drop);
    bit ok;
    int n;
    logic [W-1:0] saved;
    i_Req = req;
    wait_grant(ok);
    if (!ok) begin
      i_Req = '0;
      return;
    end
    check("grant", o_Grant, 32'(1 << w));
    check("grant_data", o_Data16, d);
    if (drop) i_Req = '0;
    saved = i_Data[w*W +: W];
    i_Data[w*W +: W] = ~d;
    tick();
    check("start", {o_Start, o_Busy, o_Grant}, {1'b1, 1'b1, 4'b0});
    ok = 1'b1;
    for (int k = 1; k < lat; k++) begin
      if (k == lat / 2) i_Data[w*W +: W] = W'($urandom);
      tick();
      if (o_Done != '0 || o_TimeoutErr || o_Start || o_Data16 != d) ok = 1'b0;
    end
    check("wait_quiet", ok, 1);
    i_LEDLatch = 1'b1;
    tick();
    i_LEDLatch = 1'b0;
    check("done", o_Done, 32'(1 << w));
    check("done_excl", {o_TimeoutErr, o_Grant}, 0);
    n = 0;
    ok = 1'b1;
    while (o_Busy && n < 40) begin
      if (n == 3) i_Data[w*W +: W] = W'($urandom);
      tick();
      n++;
      if (o_Data16 != d || o_Done != '0) ok = 1'b0;
    end
    check("hold_len", n, HOLD_CYC);
    check("hold_stable", ok, 1);
    i_Data[w*W +: W] = saved;
  endtask

  initial begin
    bit ok;
    int n;
    int ptr;
    int w;
    logic [N-1:0] req;
    logic [W-1:0] words [N];

    tbl[0] = '{4'b1111,  3, 0, 16'h1111, 1'b0};
    tbl[1] = '{4'b1111, 10, 1, 16'h2222, 1'b0};
    tbl[2] = '{4'b1111,  1, 2, 16'h3333, 1'b0};
    tbl[3] = '{4'b1111, 25, 3, 16'h4444, 1'b0};
    tbl[4] = '{4'b1111,  5, 0, 16'h1111, 1'b0};
    tbl[5] = '{4'b1010,  4, 1, 16'h2222, 1'b0};
    tbl[6] = '{4'b1010,  7, 3, 16'h4444, 1'b0};
    tbl[7] = '{4'b0110,  2, 1, 16'h2222, 1'b1};

    // reset state
    #100;
    check("rst_grant", o_Grant, 0);
    check("rst_done", o_Done, 0);
    check("rst_misc", {o_TimeoutErr, o_Start, o_Busy}, 0);
    check("rst_data", o_Data16, 0);
    i_RESET = 1'b1;
    tick();

    // single request, driver latches 40 cycles after start
    i_Data[15:0] = 16'h4886;
    run_frame(4'b0001, 40, 0, 16'h4886, 1'b1);
    check("idle_keeps_data", o_Data16, 16'h4886);

    // round-robin table from a fresh pointer
    do_reset();
    i_Data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    foreach (tbl[i]) run_frame(tbl[i].req, tbl[i].lat, tbl[i].w, tbl[i].d, tbl[i].drop);
    i_Req = '0;

    // timeout: driver never latches
    i_Req = 4'b0100;
    wait_grant(ok);
    i_Req = '0;
    if (ok) begin
      check("tmo_grant", o_Grant, 4'b0100);
      tick();
      n = 0;
      ok = 1'b1;
      while (!o_TimeoutErr && n < 1100) begin
        tick();
        n++;
        if (o_Done != '0) ok = 1'b0;
      end
      check("tmo_cycles", n, TMO);
      check("tmo_no_done", ok, 1);
      check("tmo_idle", {o_Busy, o_Done, o_Grant}, 0);
      tick();
      check("tmo_pulse", o_TimeoutErr, 0);
    end
    run_frame(4'b0100, 5, 2, 16'h3333, 1'b1);

    // latch edge on the final timeout cycle wins
    run_frame(4'b0001, TMO, 0, 16'h1111, 1'b1);

    // latch stuck high into WAIT_LATCH is not an edge
    i_LEDLatch = 1'b1;
    i_Req = 4'b0010;
    wait_grant(ok);
    i_Req = '0;
    if (ok) begin
      check("stuck_data", o_Data16, 16'h2222);
      tick();
      ok = 1'b1;
      repeat (6) begin
        tick();
        if (o_Done != '0 || !o_Busy) ok = 1'b0;
      end
      check("stuck_no_done", ok, 1);
      i_LEDLatch = 1'b0;
      tick();
      i_LEDLatch = 1'b1;
      tick();
      i_LEDLatch = 1'b0;
      check("stuck_done", o_Done, 4'b0010);
      n = 0;
      while (o_Busy && n < 40) begin
        tick();
        n++;
      end
      check("stuck_hold", n, HOLD_CYC);
    end

    // asynchronous reset in the middle of WAIT_LATCH
    i_Data[15:0] = 16'hA5A5;
    i_Req = 4'b0001;
    wait_grant(ok);
    i_Req = '0;
    repeat (4) tick();
    check("pre_rst_busy", o_Busy, 1);
    #2 i_RESET = 1'b0;
    #1;
    check("mid_rst_ctl", {o_Grant, o_Done, o_TimeoutErr, o_Start, o_Busy}, 0);
    check("mid_rst_data", o_Data16, 0);
    tick();
    i_RESET = 1'b1;
    ok = 1'b1;
    repeat (3) begin
      tick();
      if (o_Done != '0 || o_TimeoutErr || o_Busy) ok = 1'b0;
    end
    check("post_rst_quiet", ok, 1);
    i_Data[15:0] = 16'h1111;
    run_frame(4'b0010, 6, 1, 16'h2222, 1'b1);
    do_reset();
    run_frame(4'b0011, 6, 0, 16'h1111, 1'b1);

    // randomized frames against the round-robin model
    do_reset();
    ptr = 0;
    for (int it = 0; it < 20; it++) begin
      req = N'($urandom_range(1, (1 << N) - 1));
      for (int k = 0; k < N; k++) begin
        words[k] = W'($urandom);
        i_Data[k*W +: W] = words[k];
      end
      w = ptr;
      while (!req[w]) w = (w + 1) % N;
      ptr = (w + 1) % N;
      run_frame(req, $urandom_range(1, 30), w, words[w], 1'($urandom_range(0, 1)));
    end
    i_Req = '0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
